sar_conv_sequencer: RTL and testbench

//  Drives the 10-bit TSCS SAR logic as a free-running or one-shot converter. Issues cnvst, waits
//  for eoc, captures sar[9:0] in the eoc cycle and buffers results in a FWFT FIFO with a

---
 rtl/sar_conv_sequencer.sv | 172 +++++++++++++++++
 tb/tb_sar_conv_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_conv_sequencer.sv
// sar_conv_sequencer
//   Runs the SAR converter either free-running (enable) or one conversion at a
//   time (single_shot). Each conversion issues a one-cycle cnvst pulse, then
//   waits for eoc and captures sar in that cycle. Results go into a
//   first-word-fall-through FIFO that is drained over a valid/ready interface.
//   The block keeps a sticky flag for samples lost to a full FIFO (overrun) and
//   one for conversions aborted without eoc (timeout).
//
// Ports
//   clk, rst_n        clock (posedge) and asynchronous active-low reset
//   enable            1 = free-running conversions
//   single_shot       pulse: one conversion if idle and enable=0
//   rate_div[7:0]     idle gap between the end of a conversion and the next start
//   clr_flags         pulse: clears overrun and timeout
//   cnvst             conversion start to the SAR logic (1-cycle pulse)
//   eoc, sar          end of conversion and result from the SAR logic
//   m_valid, m_ready  output handshake; m_data is the FIFO head
//   fifo_level[2:0]   number of entries held
//   busy              conversion in progress (START or CONV)
//   overrun, timeout  sticky status flags
//   conv_count[15:0]  number of samples written into the FIFO (wraps)
module sar_conv_sequencer #(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              single_shot,
  input  logic [7:0]        rate_div,
  input  logic              clr_flags,
  output logic              cnvst,
  input  logic              eoc,
  input  logic [DATA_W-1:0] sar,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [2:0]        fifo_level,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  output logic [15:0]       conv_count
);

  localparam int         PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [2:0] DEPTH_L  = 3'(FIFO_DEPTH);
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_CONV, S_GAP} state_t;

  state_t            state_q;
  logic [7:0]        timer_q;
  logic [7:0]        gap_q;
  logic              cnvst_q;
  logic              busy_q;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]        level_q, level_d;
  logic [15:0]       count_q, count_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;

  logic push, pop, full, wr_ok, drop, tmo_hit;

  // eoc only counts while a conversion is actually outstanding.
  assign push    = (state_q == S_CONV) & eoc;
  assign pop     = (level_q != 3'd0) & m_ready;
  assign full    = (level_q == DEPTH_L);
  // A pop in the same cycle frees the slot the incoming sample needs.
  assign wr_ok   = push & (~full | pop);
  assign drop    = push & full & ~pop;
  assign tmo_hit = (state_q == S_CONV) & ~eoc & (timer_q == 8'd0);

  // Sequencer FSM; cnvst and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= 8'd0;
      gap_q   <= 8'd0;
      cnvst_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable || single_shot) begin
            state_q <= S_START;
            cnvst_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          cnvst_q <= 1'b0;
          timer_q <= TMO_LOAD;
          state_q <= S_CONV;
        end
        S_CONV: begin
          if (eoc || timer_q == 8'd0) begin
            // rate_div is captured here only; later changes do not stretch this gap.
            gap_q   <= rate_div;
            busy_q  <= 1'b0;
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q - 8'd1;
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) state_q <= S_IDLE;
          else               gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    level_d   = level_q;
    count_d   = count_q;
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_q + 16'd1;
    end
    case ({wr_ok, pop})
      2'b10:   level_d = level_q + 3'd1;
      2'b01:   level_d = level_q - 3'd1;
      default: level_d = level_q;
    endcase
    // A set event in the same cycle as clr_flags keeps the flag set.
    overrun_d = drop    | (overrun_q & ~clr_flags);
    timeout_d = tmo_hit | (timeout_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      level_q   <= 3'd0;
      count_q   <= 16'd0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      level_q   <= level_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      timeout_q <= timeout_d;
    end
  end

  // Sample storage carries no reset; validity is tracked by level_q alone.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= sar;
  end

  assign cnvst      = cnvst_q;
  assign busy       = busy_q;
  assign m_valid    = (level_q != 3'd0);
  // Head is gated so an empty FIFO (including right after reset) presents zero
  // instead of stale storage.
  assign m_data     = m_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;
  assign conv_count = count_q;

endmodule

// File: tb/tb_sar_conv_sequencer.sv
module tb_sar_conv_sequencer;

  localparam int DATA_W  = 10;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              enable = 1'b0;
  logic              single_shot = 1'b0;
  logic [7:0]        rate_div = 8'd0;
  logic              clr_flags = 1'b0;
  logic              cnvst;
  logic              eoc = 1'b0;
  logic [DATA_W-1:0] sar = '0;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_data;
  logic [2:0]        fifo_level;
  logic              busy;
  logic              overrun;
  logic              timeout;
  logic [15:0]       conv_count;

  sar_conv_sequencer #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .single_shot(single_shot),
    .rate_div(rate_div), .clr_flags(clr_flags), .cnvst(cnvst), .eoc(eoc), .sar(sar),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .fifo_level(fifo_level),
    .busy(busy), .overrun(overrun), .timeout(timeout), .conv_count(conv_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: conversion timeline kept as cycle numbers, FIFO as a queue.
  bit                in_flight = 1'b0;
  int                start_cyc = -100;
  int                idle_cyc  = 1 << 30;
  logic [DATA_W-1:0] q[$];
  logic [15:0]       m_cnt = 16'd0;
  bit                m_ovr = 1'b0;
  bit                m_to  = 1'b0;
  int                eoc_cyc = -1;
  logic [DATA_W-1:0] eoc_val = '0;
  int                rel_cyc = -1;

  // Stimulus knobs (percentages and ranges).
  int p_en = 0, p_ss = 0, p_rdy = 100, p_clr = 0, p_stray = 0;
  int rd_lo = 0, rd_hi = 0, lat_lo = 10, lat_hi = 10;
  bit seq_mode = 1'b0;
  logic [DATA_W-1:0] seq = '0;
  bit chk_period = 1'b0;
  int period_exp = 0;
  int last_cnvst = -1;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit roll(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  task automatic step();
    bit window, pop, accept, ovr_set, to_set;
    int lat;
    @(negedge clk);
    // Compare DUT outputs for this cycle against the model.
    chk_val("cnvst", cnvst, in_flight && cyc == start_cyc);
    chk_val("busy", busy, in_flight && cyc >= start_cyc);
    chk_val("m_valid", m_valid, q.size() != 0);
    chk_val("fifo_level", fifo_level, q.size());
    if (q.size() != 0) chk_val("m_data", m_data, q[0]);
    chk_val("conv_count", conv_count, m_cnt);
    chk_val("overrun", overrun, m_ovr);
    chk_val("timeout", timeout, m_to);
    if (chk_period && cnvst) begin
      if (last_cnvst >= 0) chk_val("cnvst_period", cyc - last_cnvst, period_exp);
      last_cnvst = cyc;
    end

    // Drive inputs for this cycle.
    if (!rst_n && cyc == rel_cyc) begin
      rst_n = 1'b1;
      idle_cyc = cyc;
    end
    enable      = roll(p_en);
    single_shot = roll(p_ss);
    m_ready     = roll(p_rdy);
    clr_flags   = roll(p_clr);
    rate_div    = 8'($urandom_range(rd_hi, rd_lo));
    window      = in_flight && cyc > start_cyc;
    if (cyc == eoc_cyc) begin
      eoc = 1'b1; sar = eoc_val;
    end else if (!window && roll(p_stray)) begin
      eoc = 1'b1; sar = DATA_W'($urandom);
    end else begin
      eoc = 1'b0; sar = DATA_W'($urandom);
    end

    // Advance the model by the cycle just driven.
    if (rst_n) begin
      pop = (q.size() != 0) && m_ready;
      accept = 1'b0; ovr_set = 1'b0; to_set = 1'b0;
      if (window) begin
        if (eoc) begin
          if (q.size() < DEPTH || pop) accept = 1'b1;
          else ovr_set = 1'b1;
          in_flight = 1'b0;
          idle_cyc = cyc + int'(rate_div) + 2;
        end else if (cyc == start_cyc + TIMEOUT) begin
          to_set = 1'b1;
          in_flight = 1'b0;
          idle_cyc = cyc + int'(rate_div) + 2;
        end
      end else if (!in_flight && cyc >= idle_cyc && (enable || single_shot)) begin
        in_flight = 1'b1;
        start_cyc = cyc + 1;
        lat = $urandom_range(lat_hi, lat_lo);
        eoc_cyc = start_cyc + lat;
        if (seq_mode) begin
          seq = seq + 1'b1;
          eoc_val = seq;
        end else begin
          eoc_val = DATA_W'($urandom);
        end
      end
      if (pop) void'(q.pop_front());
      if (accept) begin
        q.push_back(sar);
        m_cnt = m_cnt + 16'd1;
      end
      m_ovr = ovr_set || (m_ovr && !clr_flags);
      m_to  = to_set  || (m_to  && !clr_flags);
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic model_reset();
    in_flight = 1'b0;
    idle_cyc  = 1 << 30;
    q.delete();
    m_cnt = 16'd0;
    m_ovr = 1'b0;
    m_to  = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk_val({pfx, "_cnvst"}, cnvst, 0);
    chk_val({pfx, "_m_valid"}, m_valid, 0);
    chk_val({pfx, "_busy"}, busy, 0);
    chk_val({pfx, "_overrun"}, overrun, 0);
    chk_val({pfx, "_timeout"}, timeout, 0);
    chk_val({pfx, "_m_data"}, m_data, 0);
    chk_val({pfx, "_level"}, fifo_level, 0);
    chk_val({pfx, "_count"}, conv_count, 0);
  endtask

  initial begin
    int guard;
    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("por");
    model_reset();
    rel_cyc = 3;
    run(6);

    // Free-running, no gap, latency 20: period 20+0+3.
    p_en = 100; p_rdy = 100; rd_lo = 0; rd_hi = 0; lat_lo = 20; lat_hi = 20;
    chk_period = 1'b1; period_exp = 23; last_cnvst = -1;
    run(120);
    chk_period = 1'b0;

    // enable drops mid-run; current conversion finishes, then single shots.
    p_en = 0; lat_lo = 10; lat_hi = 10; rd_lo = 1; rd_hi = 1;
    run(30);
    p_ss = 100; step(); p_ss = 0;
    run(5);
    p_ss = 100; step(); p_ss = 0;
    run(30);

    // Consumer stalled: FIFO fills with 1,2,3,4 and later samples are dropped.
    p_rdy = 0; seq_mode = 1'b1; seq = '0; lat_lo = 5; lat_hi = 5; rd_lo = 1; rd_hi = 1;
    p_en = 100;
    run(45);
    p_en = 0;
    run(20);
    p_rdy = 100;
    run(10);
    p_clr = 100; step(); p_clr = 0;
    run(3);
    seq_mode = 1'b0;

    // SAR never answers: every conversion times out.
    p_en = 100; lat_lo = 5000; lat_hi = 5000; rd_lo = 2; rd_hi = 2;
    run(100);
    p_en = 0;
    run(40);
    p_clr = 100; step(); p_clr = 0;

    // Randomized mix including full-FIFO push/pop collisions and stray eoc.
    p_en = 70; p_ss = 10; p_rdy = 40; p_clr = 3; p_stray = 5;
    rd_lo = 0; rd_hi = 4; lat_lo = 1; lat_hi = 34;
    run(3000);
    p_en = 100; p_ss = 0; p_rdy = 30; p_clr = 0; lat_lo = 1; lat_hi = 6; rd_lo = 0; rd_hi = 1;
    run(1500);

    // Reset in the middle of a conversion; its late eoc must be ignored.
    p_stray = 0; p_rdy = 100; lat_lo = 30; lat_hi = 30; p_en = 100;
    guard = 0;
    while (!(in_flight && cyc > start_cyc + 3) && guard < 300) begin
      step();
      guard++;
    end
    chk_val("reset_wait_conv", (in_flight && cyc > start_cyc + 3), 1);
    p_en = 0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid");
    model_reset();
    rel_cyc = cyc + 2;
    run(45);
    p_en = 100; lat_lo = 8; lat_hi = 8;
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
